control_block: RTL and testbench

//  Hardwired microsequencer of the 8-bit accumulator CPU. A 12-step T-state counter runs a fixed
//  3-step fetch, then decodes the IR opcode into one-hot bus-enable, ALU-select and shift-mode

---
 rtl/control_pkg.sv | 118 +++++++++++
 rtl/control_block_t_state_counter.sv | 35 +++
 rtl/control_block.sv | 192 +++++++++++++++++++
 tb/tb_control_block.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared constants for the accumulator-CPU microsequencer.
// Holds the opcode map, the T-state encoding, the ACC shift-mode codes, the
// bundled strobe payload, and the per-opcode last-step lookup used when
// CTRL_EARLY_END_EN is defined.
package control_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned SH_W   = 2;

    // T-states, T1 first
    typedef enum logic [STEP_W-1:0] {
        T1  = 4'd0,
        T2  = 4'd1,
        T3  = 4'd2,
        T4  = 4'd3,
        T5  = 4'd4,
        T6  = 4'd5,
        T7  = 4'd6,
        T8  = 4'd7,
        T9  = 4'd8,
        T10 = 4'd9,
        T11 = 4'd10,
        T12 = 4'd11
    } step_e;

    // ACC high/low shift modes
    localparam logic [SH_W-1:0] SH_HOLD = 2'b00;
    localparam logic [SH_W-1:0] SH_SHR  = 2'b01;
    localparam logic [SH_W-1:0] SH_SHL  = 2'b10;
    localparam logic [SH_W-1:0] SH_LOAD = 2'b11;

    // Opcode map
    localparam logic [OP_W-1:0] OP_NOP      = 8'h00;
    localparam logic [OP_W-1:0] OP_CLA      = 8'h07;
    localparam logic [OP_W-1:0] OP_LDM      = 8'h0B;
    localparam logic [OP_W-1:0] OP_LDI_TMP  = 8'h10;
    localparam logic [OP_W-1:0] OP_LDI_C    = 8'h14;
    localparam logic [OP_W-1:0] OP_LDI_D    = 8'h15;
    localparam logic [OP_W-1:0] OP_LDI_R    = 8'h16;
    localparam logic [OP_W-1:0] OP_MOVB_TMP = 8'h50;
    localparam logic [OP_W-1:0] OP_MOVB_C   = 8'h52;
    localparam logic [OP_W-1:0] OP_MOVB_D   = 8'h54;
    localparam logic [OP_W-1:0] OP_ADD      = 8'h83;
    localparam logic [OP_W-1:0] OP_SUB      = 8'h84;
    localparam logic [OP_W-1:0] OP_AND      = 8'h88;
    localparam logic [OP_W-1:0] OP_MUL      = 8'h8A;
    localparam logic [OP_W-1:0] OP_DIV      = 8'h8B;
    localparam logic [OP_W-1:0] OP_SHL      = 8'h8C;
    localparam logic [OP_W-1:0] OP_SHR      = 8'h8D;
    localparam logic [OP_W-1:0] OP_IN       = 8'h98;
    localparam logic [OP_W-1:0] OP_KEY      = 8'h9A;
    localparam logic [OP_W-1:0] OP_OUT      = 8'hA0;
    localparam logic [OP_W-1:0] OP_OUT_BOTH = 8'hA1;
    localparam logic [OP_W-1:0] OP_KOUT     = 8'hA2;
    localparam logic [OP_W-1:0] OP_JMP      = 8'hA8;
    localparam logic [OP_W-1:0] OP_JZ       = 8'hB0;
    localparam logic [OP_W-1:0] OP_JS       = 8'hB9;
    localparam logic [OP_W-1:0] OP_JNZ      = 8'hBD;
    localparam logic [OP_W-1:0] OP_STA_TMP  = 8'hD0;
    localparam logic [OP_W-1:0] OP_STA_C    = 8'hD2;
    localparam logic [OP_W-1:0] OP_STA_D    = 8'hD4;
    localparam logic [OP_W-1:0] OP_STA_R    = 8'hD6;

    // Datapath strobe bundle
    typedef struct packed {
        logic            pc_oen;
        logic            pc_inc;
        logic            load_pc;
        logic            mar_inen;
        logic            rom_en;
        logic            mdr_inen;
        logic            mdr_oen;
        logic            ir_inen;
        logic            tmp_inen;
        logic            tmp_oen;
        logic            creg_inen;
        logic            creg_oen;
        logic            dreg_inen;
        logic            dreg_oen;
        logic            rreg_inen;
        logic            rreg_oen;
        logic            breg_inen;
        logic            inreg_oen;
        logic            keych_oen;
        logic            outreg_inen;
        logic            keyout_inen;
        logic            acc_oen;
        logic            ah_inen;
        logic            ah_reset;
        logic            adds;
        logic            subs;
        logic            ands;
        logic            muls;
        logic            divs;
        logic [SH_W-1:0] hs;
        logic [SH_W-1:0] ls;
    } ctrl_t;

    // Last step carrying a non-NOP strobe for each opcode (undefined -> fetch only)
    function automatic step_e last_step(input logic [OP_W-1:0] op);
        step_e s;
        case (op)
            OP_LDM:                                   s = T8;
            OP_MUL, OP_DIV:                           s = T12;
            OP_LDI_TMP, OP_LDI_C, OP_LDI_D, OP_LDI_R,
            OP_JMP, OP_JZ, OP_JS, OP_JNZ:             s = T6;
            OP_CLA, OP_MOVB_TMP, OP_MOVB_C, OP_MOVB_D,
            OP_STA_TMP, OP_STA_C, OP_STA_D, OP_STA_R,
            OP_ADD, OP_SUB, OP_AND, OP_SHL, OP_SHR,
            OP_IN, OP_KEY, OP_OUT, OP_OUT_BOTH,
            OP_KOUT:                                  s = T4;
            default:                                  s = T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_block_t_state_counter.sv
// t_state_counter: T1..T12 step counter of the microsequencer.
// Ports: clk (rising edge), clr (async active-high, forces/holds T1),
//        early_end (return to T1 on the next edge), step (current T-state).
module t_state_counter
    import control_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  logic  early_end,
    output step_e step
);

    step_e step_q;
    step_e step_d;

    // Next step: wrap after T12 or when the instruction ends early
    always_comb begin
        if (early_end || (step_q == T12)) begin
            step_d = T1;
        end else begin
            step_d = step_e'(STEP_W'(step_q) + STEP_W'(1));
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step_q <= T1;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/control_block.sv
// control_block: hardwired microsequencer of the 8-bit accumulator CPU.
// Runs a 3-step fetch then decodes the IR opcode into bus-enable, ALU-select
// and ACC shift-mode strobes. Strobes are combinational from (step, opcode,
// flags) and are all low while clr is high.
// Ports: clk, clr (async active-high), opcode[7:0], z_f, s_f in;
//        PC/MAR/ROM/MDR/IR/TMP/C/D/R/B/IO/ACC/AH strobes, ALU selects,
//        hs[1:0]/ls[1:0] shift modes out.
// Build option: CTRL_EARLY_END_EN shortens each instruction to its last
//               active step; otherwise every instruction takes 12 clocks.
module control_block
    import control_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic [OP_W-1:0] opcode,
    input  logic            z_f,
    input  logic            s_f,
    output logic            pc_oen,
    output logic            pc_inc,
    output logic            load_pc,
    output logic            mar_inen,
    output logic            rom_en,
    output logic            mdr_inen,
    output logic            mdr_oen,
    output logic            ir_inen,
    output logic            tmp_inen,
    output logic            tmp_oen,
    output logic            creg_inen,
    output logic            creg_oen,
    output logic            dreg_inen,
    output logic            dreg_oen,
    output logic            rreg_inen,
    output logic            rreg_oen,
    output logic            breg_inen,
    output logic            inreg_oen,
    output logic            keych_oen,
    output logic            outreg_inen,
    output logic            keyout_inen,
    output logic            acc_oen,
    output logic            ah_inen,
    output logic            ah_reset,
    output logic            adds,
    output logic            subs,
    output logic            ands,
    output logic            muls,
    output logic            divs,
    output logic [SH_W-1:0] hs,
    output logic [SH_W-1:0] ls
);

    step_e step;
    logic  early_end_c;
    logic  opf_c;
    ctrl_t c;

`ifdef CTRL_EARLY_END_EN
    assign early_end_c = (step == last_step(opcode));
`else
    assign early_end_c = 1'b0;
`endif

    t_state_counter u_tsc (
        .clk       (clk),
        .clr       (clr),
        .early_end (early_end_c),
        .step      (step)
    );

    // Opcodes that fetch an immediate operand in T4..T6
    assign opf_c = opcode inside {OP_LDM, OP_LDI_TMP, OP_LDI_C, OP_LDI_D, OP_LDI_R,
                                  OP_JMP, OP_JZ, OP_JS, OP_JNZ};

    // Strobe decode
    always_comb begin
        c = '0;
        if (!clr) begin
            // Instruction fetch, common to every opcode
            case (step)
                T1: begin c.pc_oen = 1'b1; c.mar_inen = 1'b1; end
                T2: begin c.rom_en = 1'b1; c.mdr_inen = 1'b1; c.pc_inc = 1'b1; end
                T3: begin c.mdr_oen = 1'b1; c.ir_inen = 1'b1; end
                default: ;
            endcase

            // Operand fetch; destination added per opcode below
            if (opf_c) begin
                case (step)
                    T4: begin c.pc_oen = 1'b1; c.mar_inen = 1'b1; end
                    T5: begin c.rom_en = 1'b1; c.mdr_inen = 1'b1; c.pc_inc = 1'b1; end
                    T6: c.mdr_oen = 1'b1;
                    default: ;
                endcase
            end

            case (opcode)
                OP_CLA: if (step == T4) c.ah_reset = 1'b1;
                OP_LDM: begin
                    // Operand is an address: reload MAR then read the data byte
                    case (step)
                        T6: c.mar_inen = 1'b1;
                        T7: begin c.rom_en = 1'b1; c.mdr_inen = 1'b1; end
                        T8: begin c.mdr_oen = 1'b1; c.tmp_inen = 1'b1; end
                        default: ;
                    endcase
                end
                OP_LDI_TMP: if (step == T6) c.tmp_inen  = 1'b1;
                OP_LDI_C:   if (step == T6) c.creg_inen = 1'b1;
                OP_LDI_D:   if (step == T6) c.dreg_inen = 1'b1;
                OP_LDI_R:   if (step == T6) c.rreg_inen = 1'b1;
                OP_MOVB_TMP: if (step == T4) begin c.tmp_oen  = 1'b1; c.breg_inen = 1'b1; end
                OP_MOVB_C:   if (step == T4) begin c.creg_oen = 1'b1; c.breg_inen = 1'b1; end
                OP_MOVB_D:   if (step == T4) begin c.dreg_oen = 1'b1; c.breg_inen = 1'b1; end
                OP_STA_TMP: if (step == T4) begin c.acc_oen = 1'b1; c.tmp_inen  = 1'b1; end
                OP_STA_C:   if (step == T4) begin c.acc_oen = 1'b1; c.creg_inen = 1'b1; end
                OP_STA_D:   if (step == T4) begin c.acc_oen = 1'b1; c.dreg_inen = 1'b1; end
                OP_STA_R:   if (step == T4) begin c.acc_oen = 1'b1; c.rreg_inen = 1'b1; end
                OP_ADD, OP_SUB, OP_AND: begin
                    if (step == T4) begin
                        c.adds    = (opcode == OP_ADD);
                        c.subs    = (opcode == OP_SUB);
                        c.ands    = (opcode == OP_AND);
                        c.ah_inen = 1'b1;
                        c.hs      = SH_LOAD;
                        c.ls      = SH_LOAD;
                    end
                end
                OP_MUL, OP_DIV: begin
                    // Clear AH, then eight shift-and-accumulate steps T5..T12
                    if (step == T4) begin
                        c.ah_reset = 1'b1;
                    end else if (step >= T5) begin
                        c.muls    = (opcode == OP_MUL);
                        c.divs    = (opcode == OP_DIV);
                        c.ah_inen = 1'b1;
                        c.hs      = (opcode == OP_MUL) ? SH_SHL : SH_SHR;
                        c.ls      = (opcode == OP_MUL) ? SH_SHL : SH_SHR;
                    end
                end
                OP_SHL: if (step == T4) begin c.hs = SH_SHL; c.ls = SH_SHL; end
                OP_SHR: if (step == T4) begin c.hs = SH_SHR; c.ls = SH_SHR; end
                OP_IN:  if (step == T4) begin c.inreg_oen = 1'b1; c.breg_inen = 1'b1; end
                OP_KEY: if (step == T4) begin c.keych_oen = 1'b1; c.breg_inen = 1'b1; end
                OP_OUT: if (step == T4) begin c.acc_oen = 1'b1; c.outreg_inen = 1'b1; end
                OP_KOUT: if (step == T4) begin c.acc_oen = 1'b1; c.keyout_inen = 1'b1; end
                OP_OUT_BOTH: if (step == T4) begin
                    c.acc_oen     = 1'b1;
                    c.outreg_inen = 1'b1;
                    c.keyout_inen = 1'b1;
                end
                // Jumps: PC load from the fetched operand, flag sampled at T6
                OP_JMP: if (step == T6) c.load_pc = 1'b1;
                OP_JZ:  if (step == T6) c.load_pc = z_f;
                OP_JS:  if (step == T6) c.load_pc = s_f;
                OP_JNZ: if (step == T6) c.load_pc = !z_f;
                default: ;
            endcase
        end
    end

    assign pc_oen      = c.pc_oen;
    assign pc_inc      = c.pc_inc;
    assign load_pc     = c.load_pc;
    assign mar_inen    = c.mar_inen;
    assign rom_en      = c.rom_en;
    assign mdr_inen    = c.mdr_inen;
    assign mdr_oen     = c.mdr_oen;
    assign ir_inen     = c.ir_inen;
    assign tmp_inen    = c.tmp_inen;
    assign tmp_oen     = c.tmp_oen;
    assign creg_inen   = c.creg_inen;
    assign creg_oen    = c.creg_oen;
    assign dreg_inen   = c.dreg_inen;
    assign dreg_oen    = c.dreg_oen;
    assign rreg_inen   = c.rreg_inen;
    assign rreg_oen    = c.rreg_oen;
    assign breg_inen   = c.breg_inen;
    assign inreg_oen   = c.inreg_oen;
    assign keych_oen   = c.keych_oen;
    assign outreg_inen = c.outreg_inen;
    assign keyout_inen = c.keyout_inen;
    assign acc_oen     = c.acc_oen;
    assign ah_inen     = c.ah_inen;
    assign ah_reset    = c.ah_reset;
    assign adds        = c.adds;
    assign subs        = c.subs;
    assign ands        = c.ands;
    assign muls        = c.muls;
    assign divs        = c.divs;
    assign hs          = c.hs;
    assign ls          = c.ls;

endmodule

// File: tb/tb_control_block.sv
// Testbench for control_block: directed instruction sequences with
// hand-computed per-step strobe vectors, queued by the stimulus process and
// checked by an independent negedge monitor.
module tb_control_block;

    typedef logic [32:0] vec_t;
    typedef vec_t vec12_t [12];

    typedef struct {
        string name;
        vec_t  v;
        bit    exact;
    } exp_t;

`ifdef CTRL_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // Strobe bit positions in the packed observation vector
    localparam vec_t PC_OEN      = 33'h1 << 0;
    localparam vec_t PC_INC      = 33'h1 << 1;
    localparam vec_t LOAD_PC     = 33'h1 << 2;
    localparam vec_t MAR_INEN    = 33'h1 << 3;
    localparam vec_t ROM_EN      = 33'h1 << 4;
    localparam vec_t MDR_INEN    = 33'h1 << 5;
    localparam vec_t MDR_OEN     = 33'h1 << 6;
    localparam vec_t IR_INEN     = 33'h1 << 7;
    localparam vec_t TMP_INEN    = 33'h1 << 8;
    localparam vec_t CREG_OEN    = 33'h1 << 11;
    localparam vec_t DREG_INEN   = 33'h1 << 12;
    localparam vec_t RREG_INEN   = 33'h1 << 14;
    localparam vec_t BREG_INEN   = 33'h1 << 16;
    localparam vec_t OUTREG_INEN = 33'h1 << 19;
    localparam vec_t KEYOUT_INEN = 33'h1 << 20;
    localparam vec_t ACC_OEN     = 33'h1 << 21;
    localparam vec_t AH_INEN     = 33'h1 << 22;
    localparam vec_t AH_RESET    = 33'h1 << 23;
    localparam vec_t ADDS        = 33'h1 << 24;
    localparam vec_t SUBS        = 33'h1 << 25;
    localparam vec_t MULS        = 33'h1 << 27;
    localparam vec_t DIVS        = 33'h1 << 28;
    localparam vec_t HS_SHR      = 33'h1 << 29;
    localparam vec_t HS_SHL      = 33'h2 << 29;
    localparam vec_t HS_LOAD     = 33'h3 << 29;
    localparam vec_t LS_SHR      = 33'h1 << 31;
    localparam vec_t LS_SHL      = 33'h2 << 31;
    localparam vec_t LS_LOAD     = 33'h3 << 31;

    localparam vec_t F1 = PC_OEN | MAR_INEN;
    localparam vec_t F2 = ROM_EN | MDR_INEN | PC_INC;
    localparam vec_t F3 = MDR_OEN | IR_INEN;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] opcode;
    logic       z_f;
    logic       s_f;
    logic       pc_oen, pc_inc, load_pc, mar_inen, rom_en, mdr_inen, mdr_oen, ir_inen;
    logic       tmp_inen, tmp_oen, creg_inen, creg_oen, dreg_inen, dreg_oen;
    logic       rreg_inen, rreg_oen, breg_inen, inreg_oen, keych_oen;
    logic       outreg_inen, keyout_inen, acc_oen, ah_inen, ah_reset;
    logic       adds, subs, ands, muls, divs;
    logic [1:0] hs, ls;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    control_block dut (
        .clk(clk), .clr(clr), .opcode(opcode), .z_f(z_f), .s_f(s_f),
        .pc_oen(pc_oen), .pc_inc(pc_inc), .load_pc(load_pc), .mar_inen(mar_inen),
        .rom_en(rom_en), .mdr_inen(mdr_inen), .mdr_oen(mdr_oen), .ir_inen(ir_inen),
        .tmp_inen(tmp_inen), .tmp_oen(tmp_oen), .creg_inen(creg_inen), .creg_oen(creg_oen),
        .dreg_inen(dreg_inen), .dreg_oen(dreg_oen), .rreg_inen(rreg_inen), .rreg_oen(rreg_oen),
        .breg_inen(breg_inen), .inreg_oen(inreg_oen), .keych_oen(keych_oen),
        .outreg_inen(outreg_inen), .keyout_inen(keyout_inen), .acc_oen(acc_oen),
        .ah_inen(ah_inen), .ah_reset(ah_reset), .adds(adds), .subs(subs), .ands(ands),
        .muls(muls), .divs(divs), .hs(hs), .ls(ls)
    );

    vec_t act;
    assign act = {ls, hs, divs, muls, ands, subs, adds, ah_reset, ah_inen, acc_oen,
                  keyout_inen, outreg_inen, keych_oen, inreg_oen, breg_inen,
                  rreg_oen, rreg_inen, dreg_oen, dreg_inen, creg_oen, creg_inen,
                  tmp_oen, tmp_inen, ir_inen, mdr_oen, mdr_inen, rom_en, mar_inen,
                  load_pc, pc_inc, pc_oen};

    // Monitor: one queued expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0] oen;
            logic [4:0] alu;
            e   = q.pop_front();
            oen = {act[0], act[6], act[9], act[11], act[13], act[15], act[17], act[18], act[21]};
            alu = act[28:24];
            if (e.exact) begin
                n_cmp++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %09h expected %09h", e.name, act, e.v);
                end
            end
            n_cmp++;
            if (!$onehot0(oen)) begin
                n_fail++;
                $display("FAIL %s bus_contention: oen=%b expected at most one high", e.name, oen);
            end
            n_cmp++;
            if (!$onehot0(alu)) begin
                n_fail++;
                $display("FAIL %s alu_select: alu=%b expected at most one high", e.name, alu);
            end
        end
    end

    function automatic vec12_t fetch_only();
        vec12_t e;
        for (int i = 0; i < 12; i++) e[i] = '0;
        e[0] = F1;
        e[1] = F2;
        e[2] = F3;
        return e;
    endfunction

    function automatic vec12_t opf(input vec_t dest);
        vec12_t e;
        e    = fetch_only();
        e[3] = F1;
        e[4] = F2;
        e[5] = MDR_OEN | dest;
        return e;
    endfunction

    function automatic int sweep_last(input logic [7:0] op);
        case (op)
            8'h00:                                        return 3;
            8'h0B:                                        return 8;
            8'h8A, 8'h8B:                                 return 12;
            8'h10, 8'h14, 8'h15, 8'h16,
            8'hA8, 8'hB0, 8'hB9, 8'hBD:                   return 6;
            default:                                      return 4;
        endcase
    endfunction

    // Entered at posedge+1 with the counter at T1
    task automatic run_instr(input logic [7:0] op, input logic [11:0] zm,
                             input logic [11:0] sm, input vec12_t e,
                             input int last, input bit exact);
        int n;
        n = EARLY ? last : 12;
        for (int i = 0; i < n; i++) begin
            exp_t x;
            opcode  = op;
            z_f     = zm[i];
            s_f     = sm[i];
            x.name  = $sformatf("op%02h_T%0d", op, i + 1);
            x.v     = e[i];
            x.exact = exact || (i < 3);
            q.push_back(x);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_zero(input string nm);
        exp_t x;
        x.name  = nm;
        x.v     = '0;
        x.exact = 1'b1;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec12_t e;
        logic [7:0] sweep [30];
        sweep = '{8'h00, 8'h07, 8'h0B, 8'h10, 8'h14, 8'h15, 8'h16, 8'h50, 8'h52, 8'h54,
                  8'hD0, 8'hD2, 8'hD4, 8'hD6, 8'h83, 8'h84, 8'h88, 8'h8A, 8'h8B, 8'h8C,
                  8'h8D, 8'h98, 8'h9A, 8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hB0, 8'hB9, 8'hBD};

        clr    = 1'b1;
        opcode = 8'h83;
        z_f    = 1'b0;
        s_f    = 1'b0;
        @(posedge clk);
        #1;
        push_zero("reset_c1");
        push_zero("reset_c2");
        clr = 1'b0;

        // NOP: fetch only, then wrap to T1 for the next instruction
        run_instr(8'h00, 12'h000, 12'h000, fetch_only(), 3, 1'b1);

        // ADD
        e = fetch_only(); e[3] = ADDS | AH_INEN | HS_LOAD | LS_LOAD;
        run_instr(8'h83, 12'h000, 12'h000, e, 4, 1'b1);

        // SUB
        e = fetch_only(); e[3] = SUBS | AH_INEN | HS_LOAD | LS_LOAD;
        run_instr(8'h84, 12'h000, 12'h000, e, 4, 1'b1);

        // MUL
        e = fetch_only(); e[3] = AH_RESET;
        for (int i = 4; i < 12; i++) e[i] = MULS | AH_INEN | HS_SHL | LS_SHL;
        run_instr(8'h8A, 12'h000, 12'h000, e, 12, 1'b1);

        // DIV
        e = fetch_only(); e[3] = AH_RESET;
        for (int i = 4; i < 12; i++) e[i] = DIVS | AH_INEN | HS_SHR | LS_SHR;
        run_instr(8'h8B, 12'h000, 12'h000, e, 12, 1'b1);

        // JZ not taken / taken
        run_instr(8'hB0, 12'h000, 12'h000, opf('0), 6, 1'b1);
        run_instr(8'hB0, 12'hFFF, 12'h000, opf(LOAD_PC), 6, 1'b1);
        // JZ with z_f high only at T6, then low only at T6
        run_instr(8'hB0, 12'h020, 12'h000, opf(LOAD_PC), 6, 1'b1);
        run_instr(8'hB0, 12'hFDF, 12'h000, opf('0), 6, 1'b1);
        // JNZ inverse
        run_instr(8'hBD, 12'h000, 12'h000, opf(LOAD_PC), 6, 1'b1);
        run_instr(8'hBD, 12'hFFF, 12'h000, opf('0), 6, 1'b1);
        // JMP always; JS on sign
        run_instr(8'hA8, 12'h000, 12'h000, opf(LOAD_PC), 6, 1'b1);
        run_instr(8'hB9, 12'hFFF, 12'h000, opf('0), 6, 1'b1);
        run_instr(8'hB9, 12'h000, 12'hFFF, opf(LOAD_PC), 6, 1'b1);

        // LDM
        e = opf(MAR_INEN); e[6] = ROM_EN | MDR_INEN; e[7] = MDR_OEN | TMP_INEN;
        run_instr(8'h0B, 12'h000, 12'h000, e, 8, 1'b1);

        // LDI R
        run_instr(8'h16, 12'h000, 12'h000, opf(RREG_INEN), 6, 1'b1);

        // STA D, MOVB C, CLA, SHL, OUT+KOUT
        e = fetch_only(); e[3] = ACC_OEN | DREG_INEN;
        run_instr(8'hD4, 12'h000, 12'h000, e, 4, 1'b1);
        e = fetch_only(); e[3] = CREG_OEN | BREG_INEN;
        run_instr(8'h52, 12'h000, 12'h000, e, 4, 1'b1);
        e = fetch_only(); e[3] = AH_RESET;
        run_instr(8'h07, 12'h000, 12'h000, e, 4, 1'b1);
        e = fetch_only(); e[3] = HS_SHL | LS_SHL;
        run_instr(8'h8C, 12'h000, 12'h000, e, 4, 1'b1);
        e = fetch_only(); e[3] = ACC_OEN | OUTREG_INEN | KEYOUT_INEN;
        run_instr(8'hA1, 12'h000, 12'h000, e, 4, 1'b1);

        // Undefined opcode behaves as NOP
        run_instr(8'hFF, 12'hFFF, 12'hFFF, fetch_only(), 3, 1'b1);

        // Abort MUL mid-instruction with clr, then restart at T1
        e = fetch_only(); e[3] = AH_RESET;
        for (int i = 4; i < 12; i++) e[i] = MULS | AH_INEN | HS_SHL | LS_SHL;
        for (int i = 0; i < 6; i++) begin
            exp_t x;
            opcode  = 8'h8A;
            x.name  = $sformatf("abort_T%0d", i + 1);
            x.v     = e[i];
            x.exact = 1'b1;
            q.push_back(x);
            @(posedge clk);
            #1;
        end
        clr = 1'b1;
        push_zero("abort_clr1");
        push_zero("abort_clr2");
        clr = 1'b0;
        e = fetch_only(); e[3] = ADDS | AH_INEN | HS_LOAD | LS_LOAD;
        run_instr(8'h83, 12'h000, 12'h000, e, 4, 1'b1);

        // Sweep every defined opcode with random flags: fetch exact, bus/ALU exclusivity
        foreach (sweep[k]) begin
            run_instr(sweep[k], 12'($urandom), 12'($urandom), fetch_only(),
                      sweep_last(sweep[k]), 1'b0);
        end

        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
